// File: rtl/histdec_pkg.sv
// Shared types and helpers for the N-stream histogram decompressor:
// FSM states, maximal-length LFSR tap masks and the rotate-priority bin picker.
package histdec_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_DONE} state_t;

  localparam int MAX_BINS = 16;

  // Fibonacci feedback masks (bit t-1 set for tap t), indexed by LFSR width.
  localparam logic [15:0] LFSR_TAPS [3:16] = '{
    16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110,
    16'h0240, 16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  // First set bit of mask at or above start_idx, wrapping modulo num_bins
  // (num_bins is a power of two). Returns start_idx if nothing is set.
  function automatic logic [3:0] next_nonzero(input logic [MAX_BINS-1:0] mask,
                                              input logic [3:0]          start_idx,
                                              input int                  num_bins);
    logic [3:0] idx;
    next_nonzero = start_idx;
    for (int i = MAX_BINS - 1; i >= 0; i--) begin
      idx = 4'((int'(start_idx) + i) & (num_bins - 1));
      if (i < num_bins && mask[idx]) next_nonzero = idx;
    end
  endfunction

endpackage

// File: rtl/histogram_decompressor_nch_lfsr.sv
// Fibonacci LFSR used to shuffle the emission order; reload on load,
// one step per advance, otherwise holds.
module lfsr_gen
  import histdec_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [15:0]      TAP_ROW = LFSR_TAPS[WIDTH];
  localparam logic [WIDTH-1:0] TAPS    = TAP_ROW[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          state <= SEED;
    else if (load)    state <= SEED;
    else if (advance) state <= {state[WIDTH-2:0], ^(state & TAPS)};
  end

endmodule

// File: rtl/histogram_decompressor_nch.sv
// Regenerates NUM_STREAMS parallel unary bitstreams from a 2^NUM_STREAMS-bin
// joint histogram, one beat per handshake, in ascending or LFSR-shuffled order.
module histogram_decompressor_nch
  import histdec_pkg::*;
#(
  parameter int NUM_STREAMS   = 2,
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1),
  parameter int LFSR_WIDTH    = 8,
  parameter int LFSR_SEED     = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic                                            shuffle_en,
  input  logic [(1 << NUM_STREAMS)*COUNTER_WIDTH-1:0]     counts,
  output logic [NUM_STREAMS-1:0]                          stream_bits,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            error
);

  localparam int NUM_BINS = 1 << NUM_STREAMS;
  localparam int SUM_W    = COUNTER_WIDTH + NUM_STREAMS;

  state_t                                  state_q, state_d;
  logic [NUM_BINS-1:0][COUNTER_WIDTH-1:0]  bins_q;
  logic                                    shuffle_q;
  logic [LFSR_WIDTH-1:0]                   lfsr;
  logic [SUM_W-1:0]                        bin_sum;
  logic [MAX_BINS-1:0]                     nz_mask;
  logic [3:0]                              cand, sel_full;
  logic [NUM_STREAMS-1:0]                  sel;
  logic                                    accept, handshake, load_beat, overflow;

  assign accept    = (state_q == S_IDLE) && start;
  assign handshake = out_valid && out_ready;
  assign overflow  = bin_sum > SUM_W'(STREAM_LENGTH);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    nz_mask = '0;
    bin_sum = '0;
    for (int b = 0; b < NUM_BINS; b++) begin
      nz_mask[b] = |bins_q[b];
      bin_sum    = bin_sum + SUM_W'(bins_q[b]);
    end
  end

  // Ascending mode is just the rotate search anchored at bin 0.
  assign cand     = shuffle_q ? 4'(lfsr & LFSR_WIDTH'(NUM_BINS - 1)) : 4'd0;
  assign sel_full = next_nonzero(nz_mask, cand, NUM_BINS);
  assign sel      = NUM_STREAMS'(sel_full);

  lfsr_gen #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_WIDTH'(LFSR_SEED))
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance (handshake),
    .state   (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // bins_q already excludes the beat on display, so an all-zero mask at a
  // handshake means that handshake consumed the last beat.
  always_comb begin
    state_d   = state_q;
    load_beat = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (overflow || bin_sum == '0) state_d = S_DONE;
        else begin
          state_d   = S_EMIT;
          load_beat = 1'b1;
        end
      end
      S_EMIT: begin
        if (handshake) begin
          if (|nz_mask) load_beat = 1'b1;
          else          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bins_q      <= '0;
      shuffle_q   <= 1'b0;
      stream_bits <= '0;
      out_valid   <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (accept) begin
        bins_q    <= counts;
        shuffle_q <= shuffle_en;
        error     <= 1'b0;
      end
      if (state_q == S_CHECK && overflow) error <= 1'b1;
      if (load_beat) begin
        stream_bits  <= sel;
        bins_q[sel]  <= bins_q[sel] - COUNTER_WIDTH'(1);
        out_valid    <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_histogram_decompressor_nch.sv
// Randomised self-checking bench: a tally/queue model of the histogram checks
// every handshake, stall and completion of a 2-stream and a 3-stream instance.
module tb_histogram_decompressor_nch;
  localparam int CW = 8;
  localparam int SL = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start, shuffle_en, out_ready;
  logic [4*CW-1:0] counts;
  logic [1:0]      stream_bits;
  logic            out_valid, busy, done, error;

  logic            start3, shuffle3, ready3;
  logic [8*CW-1:0] counts3;
  logic [2:0]      bits3;
  logic            valid3, busy3, done3, error3;

  histogram_decompressor_nch #(.NUM_STREAMS(2), .STREAM_LENGTH(SL)) u_dut (
    .clk(clk), .rst(rst), .start(start), .shuffle_en(shuffle_en), .counts(counts),
    .stream_bits(stream_bits), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error));

  histogram_decompressor_nch #(.NUM_STREAMS(3), .STREAM_LENGTH(SL)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .shuffle_en(shuffle3), .counts(counts3),
    .stream_bits(bits3), .out_valid(valid3), .out_ready(ready3),
    .busy(busy3), .done(done3), .error(error3));

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model state for the 2-stream instance
  int  tally [4];
  int  beats[$];
  int  exp_q[$];
  int  first_valid_cyc, done_cyc, done_cnt, start_cyc;
  bit  prev_stall;
  logic [1:0] prev_bits;

  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_bits_held", stream_bits, prev_bits);
      end
      if (!busy) chk("idle_no_valid", out_valid, 0);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        tally[stream_bits]++;
        beats.push_back(int'(stream_bits));
        if (exp_q.size() > 0) chk("beat_order", stream_bits, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_bits  = stream_bits;
    end
  end

  // Model state for the 3-stream instance (always ready)
  int tally3 [8];
  int seq3[$];
  int done3_cnt, done3_cyc;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid3) begin
        tally3[bits3]++;
        seq3.push_back(int'(bits3));
      end
      if (done3) begin
        done3_cnt++;
        done3_cyc = cyc;
      end
    end
  end

  task automatic clear_model();
    tally = '{default: 0};
    beats.delete();
    exp_q.delete();
    first_valid_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
  endtask

  task automatic run_case(input string tag, input int c [4], input bit shuf,
                          input int rdy_pct, input bit dbl_start);
    int sum = 0;
    int to  = 0;
    bit exp_err;
    clear_model();
    foreach (c[b]) sum += c[b];
    exp_err = (sum > SL);
    if (!shuf && !exp_err)
      for (int b = 0; b < 4; b++)
        for (int n = 0; n < c[b]; n++) exp_q.push_back(b);
    @(posedge clk); #1;
    start = 1; shuffle_en = shuf; start_cyc = cyc;
    for (int b = 0; b < 4; b++) counts[b*CW +: CW] = CW'(c[b]);
    out_ready = ($urandom_range(99) < rdy_pct);
    @(posedge clk); #1;
    while (done_cnt == 0 && to < sum * 8 + 40) begin
      start      = (dbl_start && to == 3);
      shuffle_en = ~shuf;
      counts     = $urandom;
      out_ready  = ($urandom_range(99) < rdy_pct);
      @(posedge clk); #1;
      to++;
    end
    start = 0;
    @(posedge clk); #1;
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_beats"}, beats.size(), exp_err ? 0 : sum);
    for (int b = 0; b < 4; b++) chk({tag, "_tally"}, tally[b], exp_err ? 0 : c[b]);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_busy_after"}, busy, 0);
    if (!shuf) chk({tag, "_order_left"}, exp_q.size(), 0);
    if (rdy_pct == 100) begin
      chk({tag, "_done_latency"}, done_cyc - start_cyc, (exp_err || sum == 0) ? 2 : sum + 2);
      if (!exp_err && sum > 0) chk({tag, "_first_valid"}, first_valid_cyc - start_cyc, 2);
    end
  endtask

  initial begin
    int c [4];
    int to;
    int c3 [8];
    int sum3;
    bit asc;
    rst = 1; start = 0; shuffle_en = 0; out_ready = 1; counts = '0;
    start3 = 0; shuffle3 = 0; ready3 = 1; counts3 = '0;
    tally3 = '{default: 0}; done3_cnt = 0; done3_cyc = -1;
    clear_model();
    #1;
    chk("rst_stream_bits", stream_bits, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_valid3", valid3, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Ascending order, full throughput, plus literal pins on the sequence
    run_case("asc", '{5, 7, 0, 3}, 0, 100, 0);
    chk("lit_len", beats.size(), 15);
    if (beats.size() == 15) begin
      chk("lit_beat0", beats[0], 0);
      chk("lit_beat5", beats[5], 1);
      chk("lit_beat11", beats[11], 1);
      chk("lit_beat12", beats[12], 3);
      chk("lit_beat14", beats[14], 3);
    end

    // Backpressure with ordered output
    run_case("stall", '{20, 15, 12, 8}, 0, 50, 0);

    // Overflow then recovery
    run_case("ovf", '{100, 20, 5, 4}, 0, 100, 0);
    repeat (3) @(posedge clk);
    #1 chk("ovf_error_sticky", error, 1);
    run_case("ovf_clear", '{1, 0, 0, 0}, 0, 100, 0);

    // Empty histogram, then a run with an ignored second start
    run_case("empty", '{0, 0, 0, 0}, 0, 100, 0);
    run_case("dbl_start", '{4, 3, 2, 1}, 0, 100, 1);

    // Boundary: exactly STREAM_LENGTH
    run_case("full_len", '{32, 32, 32, 32}, 1, 100, 0);

    // Randomised histograms, order mode and readiness
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 4; b++) c[b] = $urandom_range(20);
      run_case("rand", c, 1'($urandom_range(1)), 50, 0);
    end

    // Reset mid-emission
    clear_model();
    @(posedge clk); #1;
    start = 1; shuffle_en = 0; out_ready = 1; counts = {8'd3, 8'd3, 8'd3, 8'd3};
    @(posedge clk); #1;
    start = 0;
    to = 0;
    while (beats.size() < 3 && to < 50) begin
      @(negedge clk); #1;
      to++;
    end
    chk("rst_mid_beats_seen", beats.size(), 3);
    @(posedge clk); #1;
    chk("rst_mid_pre_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_bits", stream_bits, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_error", error, 0);
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
    #1 chk("rst_mid_no_done", done_cnt, 0);
    run_case("after_rst", '{0, 0, 0, 1}, 0, 100, 0);

    // 3-stream shuffled run
    c3 = '{4, 0, 2, 6, 1, 0, 3, 9};
    sum3 = 0;
    foreach (c3[b]) sum3 += c3[b];
    @(posedge clk); #1;
    start3 = 1; shuffle3 = 1; start_cyc = cyc;
    for (int b = 0; b < 8; b++) counts3[b*CW +: CW] = CW'(c3[b]);
    @(posedge clk); #1;
    start3 = 0; counts3 = {$urandom, $urandom};
    to = 0;
    while (done3_cnt == 0 && to < 200) begin
      @(posedge clk); #1;
      to++;
    end
    chk("s3_done_count", done3_cnt, 1);
    chk("s3_beats", seq3.size(), sum3);
    for (int b = 0; b < 8; b++) chk("s3_tally", tally3[b], c3[b]);
    chk("s3_done_latency", done3_cyc - start_cyc, sum3 + 2);
    chk("s3_error", error3, 0);
    asc = 1;
    for (int i = 1; i < seq3.size(); i++) if (seq3[i] < seq3[i-1]) asc = 0;
    chk("s3_not_ascending", asc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
